// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - Serial boot-image loader that writes words into instruction RAM.
// Frame: SYNC, LEN, N x (hi, lo), checksum; the CPU is held in reset until an image checks out.
module prog_loader #(
    parameter int         width       = 16,
    parameter int         iaddr_width = 8,
    parameter logic [7:0] SYNC        = 8'hA5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [iaddr_width-1:0] iaddr_write,
    output logic [width-1:0]       idata_write,
    output logic                   i_write,
    output logic                   cpu_reset,
    output logic                   done,
    output logic                   error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int              CW       = iaddr_width + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(1) << iaddr_width;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [iaddr_width-1:0] addr_q, addr_d;
    logic [7:0]             csum_q, csum_d;
    logic [7:0]             hi_q, hi_d;
    logic                   wr_q, wr_d;
    logic [iaddr_width-1:0] waddr_q, waddr_d;
    logic [width-1:0]       wdata_q, wdata_d;
    logic                   accept;

    assign rx_ready = ~reset;
    assign accept   = rx_valid & rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            csum_q  <= '0;
            hi_q    <= '0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            csum_q  <= csum_d;
            hi_q    <= hi_d;
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        csum_d  = csum_q;
        hi_d    = hi_q;
        wr_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (accept) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (rx_data == SYNC) begin
                        state_d = S_LEN;
                        cnt_d   = '0;
                        addr_d  = '0;
                        csum_d  = '0;
                    end
                end
                S_LEN: begin
                    // A length that reads as zero in the counter means a full-size image.
                    cnt_d   = (CW'(rx_data) == '0) ? FULL_CNT : CW'(rx_data);
                    csum_d  = csum_q + rx_data;
                    state_d = S_HI;
                end
                S_HI: begin
                    hi_d    = rx_data;
                    csum_d  = csum_q + rx_data;
                    state_d = S_LO;
                end
                S_LO: begin
                    csum_d  = csum_q + rx_data;
                    wr_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = width'({hi_q, rx_data});
                    cnt_d   = cnt_q - CW'(1);
                    // Address only advances when another word follows, so it never wraps.
                    if (cnt_q == CW'(1)) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_HI;
                        addr_d  = addr_q + iaddr_width'(1);
                    end
                end
                S_CSUM: begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign i_write     = wr_q;
    assign iaddr_write = waddr_q;
    assign idata_write = wdata_q;
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERR);
    assign cpu_reset   = (state_q != S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - Directed scoreboard bench for prog_loader.
module tb_prog_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  iaddr_write;
    logic [15:0] idata_write;
    logic        i_write;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int          vectors     = 0;
    int          miscompares = 0;
    exp_t        exp_q[$];
    logic [7:0]  img_q[$];
    logic        prev_wr     = 1'b0;

    prog_loader #(.width(16), .iaddr_width(8), .SYNC(SYNC)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .iaddr_write (iaddr_write),
        .idata_write (idata_write),
        .i_write     (i_write),
        .cpu_reset   (cpu_reset),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        exp_t e;
        if (i_write === 1'b1) begin
            vectors++;
            assert (prev_wr !== 1'b1) else begin
                miscompares++;
                $error("FAIL wr_pulse: i_write high %0d cycles in a row, expected 1", 2);
            end
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_write: addr %0h data %0h, expected no write", iaddr_write, idata_write);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                assert (iaddr_write === e.a) else begin
                    miscompares++;
                    $error("FAIL wr_addr: got %0h expected %0h", iaddr_write, e.a);
                end
                vectors++;
                assert (idata_write === e.d) else begin
                    miscompares++;
                    $error("FAIL wr_data: got %0h expected %0h", idata_write, e.d);
                end
            end
        end
        prev_wr <= i_write;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        if (gaps) idle($urandom_range(0, 3));
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_image(input bit good, input bit gaps);
        logic [7:0] sum;
        logic [7:0] len;
        exp_t       e;
        int         nw;
        nw  = img_q.size() / 2;
        len = (nw == 256) ? 8'h00 : 8'(nw);
        sum = len;
        send(SYNC, gaps);
        chk("sync_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("sync_done", 32'(done), 32'd0);
        chk("sync_error", 32'(error), 32'd0);
        send(len, gaps);
        for (int i = 0; i < nw; i++) begin
            sum  = sum + img_q[2*i] + img_q[2*i+1];
            e.a  = 8'(i);
            e.d  = {img_q[2*i], img_q[2*i+1]};
            exp_q.push_back(e);
            send(img_q[2*i], gaps);
            send(img_q[2*i+1], gaps);
        end
        chk("pre_csum_cpu_reset", 32'(cpu_reset), 32'd1);
        send(good ? sum : sum + 8'd1, gaps);
        chk("writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic load_small();
        img_q.delete();
        img_q.push_back(8'h12);
        img_q.push_back(8'h34);
        img_q.push_back(8'h56);
        img_q.push_back(8'h78);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_i_write", 32'(i_write), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_rx_ready", 32'(rx_ready), 32'd1);
    endtask

    initial begin
        exp_t e;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Power-on reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("por_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("por_done", 32'(done), 32'd0);
        chk("por_error", 32'(error), 32'd0);
        chk("por_i_write", 32'(i_write), 32'd0);
        chk("por_iaddr", 32'(iaddr_write), 32'd0);
        chk("por_idata", 32'(idata_write), 32'd0);
        chk("por_rx_ready", 32'(rx_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("por_rx_ready_rel", 32'(rx_ready), 32'd1);

        // Basic two-word image
        load_small();
        send_image(1'b1, 1'b0);
        chk("img1_done", 32'(done), 32'd1);
        chk("img1_error", 32'(error), 32'd0);
        chk("img1_cpu_reset", 32'(cpu_reset), 32'd0);

        // Bad checksum, then recovery with a good image
        send_image(1'b0, 1'b0);
        chk("bad_error", 32'(error), 32'd1);
        chk("bad_done", 32'(done), 32'd0);
        chk("bad_cpu_reset", 32'(cpu_reset), 32'd1);
        send(8'h33, 1'b0);
        chk("err_ignore", 32'(error), 32'd1);
        send_image(1'b1, 1'b0);
        chk("recover_done", 32'(done), 32'd1);
        chk("recover_error", 32'(error), 32'd0);
        chk("recover_cpu_reset", 32'(cpu_reset), 32'd0);

        // Full-size image: LEN=0 means 256 words
        img_q.delete();
        for (int i = 0; i < 512; i++) img_q.push_back(8'($urandom_range(0, 255)));
        send_image(1'b1, 1'b0);
        chk("full_done", 32'(done), 32'd1);
        chk("full_cpu_reset", 32'(cpu_reset), 32'd0);

        // Non-SYNC bytes in DONE are ignored
        send(8'h00, 1'b0);
        send(8'h5A, 1'b0);
        chk("done_ignore", 32'(done), 32'd1);

        // Leading garbage from IDLE with random valid gaps
        pulse_reset();
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h5A, 1'b1);
        idle(3);
        chk("garbage_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("garbage_done", 32'(done), 32'd0);
        load_small();
        send_image(1'b1, 1'b1);
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_error", 32'(error), 32'd0);
        chk("gap_cpu_reset", 32'(cpu_reset), 32'd0);

        // Reset after the first word, then reload from address 0
        send(SYNC, 1'b0);
        send(8'h02, 1'b0);
        e.a = 8'h00;
        e.d = 16'h1234;
        exp_q.push_back(e);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        idle(1);
        chk("midload_write_seen", 32'(exp_q.size()), 32'd0);
        pulse_reset();
        idle(2);
        chk("midload_idle_cpu_reset", 32'(cpu_reset), 32'd1);
        load_small();
        send_image(1'b1, 1'b0);
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_cpu_reset", 32'(cpu_reset), 32'd0);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter width, default 16, meaning instruction word width in bits.
REQ-002 SHALL have parameter iaddr_width, default 8, meaning instruction RAM address width in bits.
REQ-003 SHALL have parameter SYNC, default 8'hA5, meaning the start-of-image byte.
REQ-004 clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx_data  input  8  incoming image byte.
REQ-007 rx_valid  input  1  rx_data is valid this cycle.
REQ-008 rx_ready  output  1  loader accepts the byte this cycle.
REQ-009 iaddr_write  output  iaddr_width  instruction RAM write address.
REQ-010 idata_write  output  width  instruction RAM write data.
REQ-011 i_write  output  1  one-cycle instruction RAM write strobe.
REQ-012 cpu_reset  output  1  hold-in-reset for the downstream CPU.
REQ-013 done  output  1  a valid image has been loaded.
REQ-014 error  output  1  the last image failed its checksum.

Function
REQ-015 SHALL accept a byte only in a cycle with rx_valid && rx_ready; rx_ready SHALL be 1 whenever reset is 0, and 0 while reset is 1.
REQ-016 SHALL implement states IDLE, LEN, HI, LO, CSUM, DONE and ERR.
REQ-017 IDLE: SHALL discard accepted bytes other than SYNC; on SYNC go to LEN.
REQ-018 LEN: the accepted byte SHALL set word count N; 0 means 2**iaddr_width words; the counter SHALL be iaddr_width+1 bits wide; go to HI.
REQ-019 HI/LO: each word SHALL be sent high byte first, then low byte (width=16); go HI->LO->HI, or LO->CSUM after word N.
REQ-020 On accepting a LO byte, the next cycle SHALL present i_write=1 for exactly one cycle, with idata_write={hi,lo} and iaddr_write=current address.
REQ-021 Address SHALL start at 0 for each image and increment by 1 after every write; the last write of a full-size image goes to 2**iaddr_width-1 and does not wrap.
REQ-022 Checksum SHALL be the 8-bit modulo-256 sum of the LEN byte and all data bytes, and SHALL restart at each SYNC.
REQ-023 CSUM: on an accepted byte equal to the running sum, go to DONE; otherwise go to ERR.
REQ-024 DONE: done=1, error=0, cpu_reset=0, starting the cycle after the checksum byte is accepted.
REQ-025 ERR: error=1, done=0, cpu_reset=1.
REQ-026 In DONE or ERR, an accepted SYNC byte SHALL go to LEN, set cpu_reset=1, clear done and error, and zero the address and checksum; other bytes are ignored.
REQ-027 cpu_reset SHALL be 1 in every state except DONE.
REQ-028 rx_valid gaps of any length between bytes SHALL not alter state; there is no timeout.
REQ-029 i_write SHALL never be asserted outside the cycle following an accepted LO byte.

Reset
REQ-030 While reset=1: state=IDLE; cpu_reset=1; done=0; error=0; i_write=0; iaddr_write=0; idata_write=0; counters and checksum=0.
REQ-031 Reset mid-load SHALL abandon the image without retracting words already written; the next image SHALL start at address 0.

Verification
REQ-032 Reset for 2 cycles -> cpu_reset=1, done=0, error=0, i_write=0, rx_ready=0, then rx_ready=1.
REQ-033 Bytes A5,02,12,34,56,78,16 -> writes (0,1234h) and (1,5678h), one cycle each; done=1 and cpu_reset=0 the cycle after byte 16.
REQ-034 Same image with checksum 17 -> both writes occur, then error=1, done=0, cpu_reset=1; a following correct image -> done=1, error=0.
REQ-035 A5,00, then 512 data bytes, then correct sum -> 256 writes to addresses 00..FF; done=1.
REQ-036 Bytes 00,FF,5A before A5, with random rx_valid gaps -> leading bytes ignored and the load result is identical to REQ-033.
REQ-037 reset pulsed after the first word of REQ-033 -> state IDLE, cpu_reset=1; re-sending the full image -> writes start at address 0 and done=1.
